// File: rtl/core_seq_pkg.sv
// Shared constants, inst bit positions and FSM state type for the core_seq sequencer.
package core_seq_pkg;

  // Array geometry
  localparam int BW       = 4;
  localparam int ROW      = 8;
  localparam int COL      = 8;
  localparam int K_W      = 3;
  localparam int IN_W     = 6;
  localparam int OUT_W    = IN_W - K_W + 1;
  localparam int LEN_KIJ  = K_W * K_W;
  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_ONIJ = OUT_W * OUT_W;

  // Datapath and address widths
  localparam int DATA_W = ROW * BW;
  localparam int ADDR_W = 11;
  localparam int INST_W = 34;

  // Weights live directly above the activations in xmem
  localparam int W_BASE = LEN_NIJ;

  // The phase counter must reach LEN_NIJ (the extra trailing l0_wr cycle of L0_A)
  localparam int CNT_W = $clog2(LEN_NIJ + 1);
  localparam int KIJ_W = $clog2(LEN_KIJ);

  // inst bit positions
  localparam int ACC       = 33;
  localparam int CEN_P     = 32;
  localparam int WEN_P     = 31;
  localparam int PADDR_LSB = 20;
  localparam int CEN_X     = 19;
  localparam int WEN_X     = 18;
  localparam int XADDR_LSB = 7;
  localparam int OFIFO_RD  = 6;
  localparam int IFIFO_WR  = 5;
  localparam int IFIFO_RD  = 4;
  localparam int L0_RD     = 3;
  localparam int L0_WR     = 2;
  localparam int EXECUTE   = 1;
  localparam int LOAD      = 0;

  // Both memories disabled (active-low enables high), no array activity
  localparam logic [INST_W-1:0] IDLE_INST = (INST_W'(1) << CEN_P) | (INST_W'(1) << WEN_P) |
                                            (INST_W'(1) << CEN_X) | (INST_W'(1) << WEN_X);

  typedef enum logic [3:0] {
    S_IDLE,
    S_XLOAD_A,
    S_XLOAD_W,
    S_L0_W,
    S_KLOAD,
    S_L0_A,
    S_EXEC,
    S_DRAIN,
    S_ACC
  } state_e;

endpackage

// File: rtl/core_seq_if.sv
// Host/core-facing signal bundle of the sequencer; master = host side, slave = sequencer.
interface core_seq_if;
  import core_seq_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic [DATA_W-1:0] D_xmem;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, in_data, ofifo_valid,
    input  in_ready, inst, D_xmem, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, ofifo_valid,
    output in_ready, inst, D_xmem, busy, done
  );

endinterface

// File: rtl/acc_addr_gen.sv
// Walks output pixels o (outer) and kernel positions k (inner) for the SFP accumulation
// pass. Both indices are held as row/column pairs so the pmem address needs only
// constant multiplies: addr = k*LEN_NIJ + (o_row+k_row)*IN_W + (o_col+k_col).
module acc_addr_gen
  import core_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam int KR_W = $clog2(K_W);
  localparam int OR_W = $clog2(OUT_W);

  logic [KR_W-1:0] r_k_row, r_k_col;
  logic [OR_W-1:0] r_o_row, r_o_col;
  logic            w_k_col_last, w_k_last, w_o_col_last, w_o_last;

  assign w_k_col_last = (r_k_col == KR_W'(K_W - 1));
  assign w_k_last     = w_k_col_last && (r_k_row == KR_W'(K_W - 1));
  assign w_o_col_last = (r_o_col == OR_W'(OUT_W - 1));
  assign w_o_last     = w_o_col_last && (r_o_row == OR_W'(OUT_W - 1));
  assign o_last       = w_k_last && w_o_last;

  assign o_addr = ADDR_W'(r_k_row) * ADDR_W'(K_W * LEN_NIJ)
                + ADDR_W'(r_k_col) * ADDR_W'(LEN_NIJ)
                + (ADDR_W'(r_o_row) + ADDR_W'(r_k_row)) * ADDR_W'(IN_W)
                + ADDR_W'(r_o_col) + ADDR_W'(r_k_col);

  // Advance k every enabled cycle; step o when k wraps; everything wraps to 0 after the last read
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_row <= '0;
      r_k_col <= '0;
      r_o_row <= '0;
      r_o_col <= '0;
    end else if (i_en) begin
      if (!w_k_col_last) begin
        r_k_col <= r_k_col + 1'b1;
      end else begin
        r_k_col <= '0;
        if (!w_k_last) begin
          r_k_row <= r_k_row + 1'b1;
        end else begin
          r_k_row <= '0;
          if (!w_o_col_last) begin
            r_o_col <= r_o_col + 1'b1;
          end else begin
            r_o_col <= '0;
            r_o_row <= w_o_last ? '0 : r_o_row + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/core_seq.sv
// Instruction sequencer for core: loads xmem from the host, then per kernel position
// loads weights into the PE array, executes, drains the ofifo into pmem, and finally
// issues the pmem read pattern for SFP accumulation. inst and D_xmem are registered.
module core_seq
  import core_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  core_seq_if.slave  bus
);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [KIJ_W-1:0]  r_kij, w_kij_nxt;
  logic [INST_W-1:0] r_inst, w_inst_nxt;
  logic [DATA_W-1:0] r_d_xmem, w_d_xmem_nxt;
  logic              r_done, w_done_nxt;
  logic              w_in_ready;
  logic              w_acc_en;
  logic              w_acc_last;
  logic [ADDR_W-1:0] w_acc_addr;

  acc_addr_gen u_acc_addr_gen (
    .clk    (clk),
    .rst_n  (reset),
    .i_en   (w_acc_en),
    .o_addr (w_acc_addr),
    .o_last (w_acc_last)
  );

  assign bus.in_ready = w_in_ready;
  assign bus.inst     = r_inst;
  assign bus.D_xmem   = r_d_xmem;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;

  // State, counters and the registered instruction/data outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_kij    <= '0;
      r_inst   <= IDLE_INST;
      r_d_xmem <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_kij    <= w_kij_nxt;
      r_inst   <= w_inst_nxt;
      r_d_xmem <= w_d_xmem_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next state, counters and the instruction word for the coming cycle
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_kij_nxt    = r_kij;
    w_inst_nxt   = IDLE_INST;
    w_d_xmem_nxt = r_d_xmem;
    w_done_nxt   = 1'b0;
    w_in_ready   = 1'b0;
    w_acc_en     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_XLOAD_A;
          w_cnt_nxt   = '0;
          w_kij_nxt   = '0;
        end
      end

      // Host activations -> xmem 0..LEN_NIJ-1
      S_XLOAD_A: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_inst_nxt[CEN_X] = 1'b0;
          w_inst_nxt[WEN_X] = 1'b0;
          w_inst_nxt[XADDR_LSB +: ADDR_W] = ADDR_W'(r_cnt);
          w_d_xmem_nxt = bus.in_data;
          if (r_cnt == CNT_W'(LEN_NIJ - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_XLOAD_W;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      // Host weights for the current kij -> xmem W_BASE..W_BASE+COL-1
      S_XLOAD_W: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_inst_nxt[CEN_X] = 1'b0;
          w_inst_nxt[WEN_X] = 1'b0;
          w_inst_nxt[XADDR_LSB +: ADDR_W] = ADDR_W'(W_BASE) + ADDR_W'(r_cnt);
          w_d_xmem_nxt = bus.in_data;
          if (r_cnt == CNT_W'(COL - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_L0_W;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      // Weights xmem -> L0; l0_wr trails each read by one cycle, last cycle is l0_wr only
      S_L0_W: begin
        if (r_cnt < CNT_W'(COL)) begin
          w_inst_nxt[CEN_X] = 1'b0;
          w_inst_nxt[XADDR_LSB +: ADDR_W] = ADDR_W'(W_BASE) + ADDR_W'(r_cnt);
        end
        if (r_cnt != '0) begin
          w_inst_nxt[L0_WR] = 1'b1;
        end
        if (r_cnt == CNT_W'(COL)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_KLOAD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // Shift the weights from L0 into the PE array
      S_KLOAD: begin
        w_inst_nxt[LOAD]  = 1'b1;
        w_inst_nxt[L0_RD] = 1'b1;
        if (r_cnt == CNT_W'(COL - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_L0_A;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // Activations xmem -> L0, same trailing-l0_wr pattern as L0_W
      S_L0_A: begin
        if (r_cnt < CNT_W'(LEN_NIJ)) begin
          w_inst_nxt[CEN_X] = 1'b0;
          w_inst_nxt[XADDR_LSB +: ADDR_W] = ADDR_W'(r_cnt);
        end
        if (r_cnt != '0) begin
          w_inst_nxt[L0_WR] = 1'b1;
        end
        if (r_cnt == CNT_W'(LEN_NIJ)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_EXEC;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // Stream activations through the array
      S_EXEC: begin
        w_inst_nxt[L0_RD]   = 1'b1;
        w_inst_nxt[EXECUTE] = 1'b1;
        if (r_cnt == CNT_W'(LEN_NIJ - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // Move partial sums ofifo -> pmem kij*LEN_NIJ+cnt, stalling while the ofifo is empty
      S_DRAIN: begin
        if (bus.ofifo_valid) begin
          w_inst_nxt[OFIFO_RD] = 1'b1;
          w_inst_nxt[CEN_P]    = 1'b0;
          w_inst_nxt[WEN_P]    = 1'b0;
          w_inst_nxt[PADDR_LSB +: ADDR_W] = ADDR_W'(r_kij) * ADDR_W'(LEN_NIJ) + ADDR_W'(r_cnt);
          if (r_cnt == CNT_W'(LEN_NIJ - 1)) begin
            w_cnt_nxt = '0;
            if (r_kij == KIJ_W'(LEN_KIJ - 1)) begin
              w_state_nxt = S_ACC;
            end else begin
              w_kij_nxt   = r_kij + 1'b1;
              w_state_nxt = S_XLOAD_W;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      // One pmem read per cycle in the accumulation order from acc_addr_gen
      S_ACC: begin
        w_acc_en           = 1'b1;
        w_inst_nxt[ACC]    = 1'b1;
        w_inst_nxt[CEN_P]  = 1'b0;
        w_inst_nxt[PADDR_LSB +: ADDR_W] = w_acc_addr;
        if (w_acc_last) begin
          w_kij_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: drives randomized host traffic and ofifo_valid, logs every
// memory transaction seen on inst, and compares the logs with an arithmetic reference model.
module tb_core_seq;

  localparam int N_ACT   = 36;
  localparam int N_W     = 8;
  localparam int N_KIJ   = 9;
  localparam int N_WORDS = N_ACT + N_KIJ * N_W;
  localparam int N_ONIJ  = 16;
  localparam logic [33:0] EXP_IDLE = 34'h1_800C_0000;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          stamp;
  } xw_t;

  logic clk = 1'b0;
  logic reset;
  core_seq_if bus ();

  core_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] words [N_WORDS];
  int ofifo_pct = 100;
  int start_pct = 0;

  // Transaction logs filled by the monitor
  xw_t q_xw [$];
  int  q_pw [$];
  int  q_pr [$];
  int  n_ofifo_rd, n_rd_bad, n_acc_bad, n_load, n_exec, n_l0_wr, n_xrd, n_done;
  int  cyc = 0;
  logic ofv_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ofv_q <= bus.ofifo_valid;
  end

  // Decode the registered inst word once per cycle, away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      if (!bus.inst[19] && !bus.inst[18]) q_xw.push_back('{int'(bus.inst[17:7]), bus.D_xmem, cyc});
      if (!bus.inst[19] &&  bus.inst[18]) n_xrd++;
      if (!bus.inst[32] && !bus.inst[31]) q_pw.push_back(int'(bus.inst[30:20]));
      if (!bus.inst[32] &&  bus.inst[31]) begin
        q_pr.push_back(int'(bus.inst[30:20]));
        if (!bus.inst[33]) n_acc_bad++;
      end
      if (bus.inst[6]) begin
        n_ofifo_rd++;
        if (!ofv_q) n_rd_bad++;
      end
      if (bus.inst[0]) n_load++;
      if (bus.inst[1]) n_exec++;
      if (bus.inst[2]) n_l0_wr++;
      if (bus.done)    n_done++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_xaddr(input int j);
    return (j < N_ACT) ? j : N_ACT + (j - N_ACT) % N_W;
  endfunction

  // Reference pmem read address for output pixel o and kernel position k
  function automatic int exp_acc(input int o, input int k);
    return k * 36 + (o / 4 + k / 3) * 6 + (o % 4 + k % 3);
  endfunction

  function automatic int pr_at(input int i);
    return (i < q_pr.size()) ? q_pr[i] : -1;
  endfunction

  function automatic int stamp_at(input int i);
    return (i < q_xw.size()) ? q_xw[i].stamp : -1;
  endfunction

  task automatic clear_logs();
    q_xw.delete(); q_pw.delete(); q_pr.delete();
    n_ofifo_rd = 0; n_rd_bad = 0; n_acc_bad = 0; n_load = 0;
    n_exec = 0; n_l0_wr = 0; n_xrd = 0; n_done = 0;
  endtask

  // One cycle of background stimulus: ofifo_valid and stray start pulses while busy
  task automatic tick();
    @(negedge clk);
    bus.ofifo_valid = ($urandom_range(99) < ofifo_pct);
    bus.start       = bus.busy && ($urandom_range(99) < start_pct);
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drive_words(input int first, input int last, input int pct_valid);
    int j = first;
    int budget = 0;
    logic hs;
    while (j <= last && budget < 4000) begin
      tick();
      bus.in_valid = ($urandom_range(99) < pct_valid);
      bus.in_data  = words[j];
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (hs) j++;
      budget++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("drive_accepted_all", 64'(j), 64'(last + 1));
  endtask

  task automatic wait_done();
    int budget = 0;
    logic got = 1'b0;
    while (!got && budget < 3000) begin
      tick();
      got = bus.done;
      budget++;
    end
    check("done_seen", 64'(got), 64'(1));
    repeat (5) tick();
  endtask

  task automatic check_run();
    check("xw_count", 64'(q_xw.size()), 64'(N_WORDS));
    for (int j = 0; j < q_xw.size() && j < N_WORDS; j++) begin
      check("xw_addr", 64'(q_xw[j].addr), 64'(exp_xaddr(j)));
      check("xw_data", 64'(q_xw[j].data), 64'(words[j]));
    end
    check("pw_count", 64'(q_pw.size()), 64'(N_KIJ * N_ACT));
    for (int j = 0; j < q_pw.size() && j < N_KIJ * N_ACT; j++)
      check("pw_addr", 64'(q_pw[j]), 64'(j));
    check("pr_count", 64'(q_pr.size()), 64'(N_ONIJ * N_KIJ));
    for (int o = 0; o < N_ONIJ; o++)
      for (int k = 0; k < N_KIJ; k++)
        check("pr_addr", 64'(pr_at(o * N_KIJ + k)), 64'(exp_acc(o, k)));
    check("acc_bit_missing", 64'(n_acc_bad), 64'(0));
    check("ofifo_rd_count", 64'(n_ofifo_rd), 64'(N_KIJ * N_ACT));
    check("ofifo_rd_no_valid", 64'(n_rd_bad), 64'(0));
    check("load_cycles", 64'(n_load), 64'(N_KIJ * N_W));
    check("exec_cycles", 64'(n_exec), 64'(N_KIJ * N_ACT));
    check("l0_wr_cycles", 64'(n_l0_wr), 64'(N_KIJ * (N_W + N_ACT)));
    check("xmem_reads", 64'(n_xrd), 64'(N_KIJ * (N_W + N_ACT)));
    check("done_pulses", 64'(n_done), 64'(1));
    check("idle_busy", 64'(bus.busy), 64'(0));
    check("idle_in_ready", 64'(bus.in_ready), 64'(0));
    check("idle_inst", 64'(bus.inst), 64'(EXP_IDLE));
  endtask

  task automatic run_full(input int pct_valid, input int pct_ofifo, input int pct_start);
    foreach (words[j]) words[j] = $urandom;
    clear_logs();
    ofifo_pct = pct_ofifo;
    start_pct = pct_start;
    do_start();
    drive_words(0, N_WORDS - 1, pct_valid);
    wait_done();
    check_run();
  endtask

  initial begin
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.ofifo_valid = 1'b0;
    clear_logs();
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_inst", 64'(bus.inst), 64'(EXP_IDLE));
    check("rst_d_xmem", 64'(bus.D_xmem), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Full-rate run with stray start pulses while busy
    run_full(100, 100, 20);
    check("nobubble_act", 64'(stamp_at(N_ACT - 1) - stamp_at(0)), 64'(N_ACT - 1));
    check("nobubble_w", 64'(stamp_at(N_ACT + N_W - 1) - stamp_at(N_ACT)), 64'(N_W - 1));
    check("acc_first0", 64'(pr_at(0)), 64'(0));
    check("acc_first1", 64'(pr_at(1)), 64'(37));
    check("acc_last", 64'(pr_at(N_ONIJ * N_KIJ - 1)), 64'(323));

    // Host backpressure and random ofifo gaps
    run_full(50, 60, 10);

    // DRAIN stall: ofifo empty for the whole kij=0 drain window
    foreach (words[j]) words[j] = $urandom;
    clear_logs();
    ofifo_pct = 0;
    start_pct = 0;
    do_start();
    drive_words(0, N_ACT + N_W - 1, 100);
    repeat (120) tick();
    check("stall_no_ofifo_rd", 64'(n_ofifo_rd), 64'(0));
    check("stall_no_pmem_wr", 64'(q_pw.size()), 64'(0));
    check("stall_busy", 64'(bus.busy), 64'(1));
    ofifo_pct = 100;
    drive_words(N_ACT + N_W, N_WORDS - 1, 100);
    wait_done();
    check_run();

    // Reset in XLOAD_W of kij=3, then a clean restart from xmem address 0
    foreach (words[j]) words[j] = $urandom;
    clear_logs();
    ofifo_pct = 100;
    do_start();
    drive_words(0, N_ACT + 3 * N_W + 2, 100);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_inst", 64'(bus.inst), 64'(EXP_IDLE));
    check("abort_in_ready", 64'(bus.in_ready), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_d_xmem", 64'(bus.D_xmem), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_full(80, 80, 10);
    check("restart_addr0", 64'((q_xw.size() > 0) ? q_xw[0].addr : -1), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
